// File: rtl/loop_step_ctl_pkg.sv
// Shared types and constants for the loop step controller.
package loop_step_pkg;

  localparam int DIGIT_W        = 4;
  localparam int DIGITS_DEFAULT = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Debug view: FSM state plus the borrow out of the MSB digit
  // (high when a decrement wraps the whole count from zero).
  typedef struct packed {
    state_t state;
    logic   wrap;
  } dbg_t;

endpackage

// File: rtl/loop_step_ctl_if.sv
// Start/step/done handshake between a loop consumer and loop_step_ctl.
//
// Handshake: START is a level request sampled on every rising edge and
// accepted only while BUSY is low; COUNT is captured on that same edge.
// STEP is a level request sampled on every rising edge and consumed only
// while the loop is running; each sampled-high STEP is one iteration.
// ABORT is sampled on every edge and wins over STEP. DONE is a one-cycle
// pulse; there is no back-pressure on DONE.
interface loop_step_ctl_if
  import loop_step_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEFAULT
);
  localparam int W = DIGIT_W * DIGITS;

  logic         START;
  logic [0:W-1] COUNT;
  logic         STEP;
  logic         ABORT;
  logic         BUSY;
  logic         LAST;
  logic         DONE;
  logic [0:W-1] REMAIN;

  // Consumer side: issues requests, observes status.
  modport master (
    output START, COUNT, STEP, ABORT,
    input  BUSY, LAST, DONE, REMAIN
  );

  // Controller side.
  modport slave (
    input  START, COUNT, STEP, ABORT,
    output BUSY, LAST, DONE, REMAIN
  );
endinterface

// File: rtl/loop_step_ctl_digit.sv
// One 4-bit down-counting slice: load, decrement on borrow-in, hold,
// zero detect and ripple borrow-out.
module loop_digit
  import loop_step_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic               bin,
  output logic [DIGIT_W-1:0] q,
  output logic               zero,
  output logic               bout
);

  logic [DIGIT_W-1:0] q_q;
  logic [DIGIT_W-1:0] q_d;

  // Next value: load wins, otherwise decrement when borrowed from.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (bin) begin
      q_d = q_q - {{(DIGIT_W-1){1'b0}}, 1'b1};
    end
  end

  // Digit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q    = q_q;
  assign zero = (q_q == '0);
  // A zero digit passes the borrow on to the next more significant digit.
  assign bout = bin & zero;

endmodule

// File: rtl/loop_step_ctl.sv
// Iteration-count controller: loads a count on START, decrements once per
// STEP through a cascade of 4-bit digits with a ripple borrow chain, and
// pulses DONE when the last iteration is consumed.
//
// Optional feature macro: LOOP_STEP_CTL_ZERO_SKIP_EN
//   defined   - START with COUNT == 0 goes straight to DONE.
//   undefined - COUNT == 0 means 2^W iterations.
module loop_step_ctl
  import loop_step_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEFAULT
)(
  input  logic            CLK,
  input  logic            RESET_N,
  loop_step_ctl_if.slave  bus,
  output dbg_t            dbg
);

  localparam int W = DIGIT_W * DIGITS;

  state_t state_q;
  state_t state_d;

  logic               load;
  logic               dec_en;
  logic               count_zero;
  logic               rem_one;
  logic               upper_zero;
  logic [0:W-1]       remain_w;
  logic [DIGITS-1:0]  dig_zero;
  logic [DIGIT_W-1:0] dig_val [DIGITS];
  // borrow[i+1] feeds digit i; borrow[DIGITS] is the step enable and
  // borrow[0] is the borrow out of the MSB digit.
  logic [DIGITS:0]    borrow;

  assign count_zero     = (bus.COUNT == '0);
  assign borrow[DIGITS] = dec_en;

  // Digit 0 is the MSB (leftmost bits of COUNT); digit DIGITS-1 is the LSB.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    loop_digit u_digit (
      .clk      (CLK),
      .rst_n    (RESET_N),
      .load     (load),
      .load_val (bus.COUNT[DIGIT_W*i +: DIGIT_W]),
      .bin      (borrow[i+1]),
      .q        (dig_val[i]),
      .zero     (dig_zero[i]),
      .bout     (borrow[i])
    );
  end

  // Assemble REMAIN and detect REMAIN == 1 from the digit outputs.
  always_comb begin
    remain_w   = '0;
    upper_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      remain_w[DIGIT_W*i +: DIGIT_W] = dig_val[i];
    end
    for (int i = 0; i < DIGITS - 1; i++) begin
      upper_zero = upper_zero & dig_zero[i];
    end
    rem_one = upper_zero && (dig_val[DIGITS-1] == {{(DIGIT_W-1){1'b0}}, 1'b1});
  end

  // Next-state and datapath controls.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    dec_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.START) begin
          load = 1'b1;
`ifdef LOOP_STEP_CTL_ZERO_SKIP_EN
          state_d = count_zero ? ST_DONE : ST_RUN;
`else
          // A zero count runs the full 2^W iterations via wrap-around.
          state_d = ST_RUN;
`endif
        end
      end
      ST_RUN: begin
        if (bus.ABORT) begin
          // REMAIN stays frozen; no DONE for an aborted loop.
          state_d = ST_IDLE;
        end else if (bus.STEP) begin
          dec_en = 1'b1;
          if (rem_one) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // Completion is already committed: ABORT and STEP are ignored.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifndef LOOP_STEP_CTL_ZERO_SKIP_EN
  // count_zero only steers the FSM when zero-skip is built in.
  logic unused_count_zero;
  assign unused_count_zero = count_zero;
`endif

  assign bus.BUSY   = (state_q != ST_IDLE);
  assign bus.DONE   = (state_q == ST_DONE);
  assign bus.LAST   = (state_q == ST_RUN) && rem_one;
  assign bus.REMAIN = remain_w;

  assign dbg.state = state_q;
  assign dbg.wrap  = borrow[0];

endmodule
